// File: rtl/temporizador_pkg.sv
// Shared types and default constants for the temporizador timing source.
package temporizador_pkg;

    typedef enum logic {
        PARADO   = 1'b0,
        CONTANDO = 1'b1
    } estado_t;

    localparam int unsigned DIV_DEFAULT        = 50000000;
    localparam int unsigned LONG_COUNT_DEFAULT = 15;

endpackage

// File: rtl/divisor_clk.sv
// Prescaler: counts 0..DIV-1 while en is high; clr clears it synchronously.
module divisor_clk
    import temporizador_pkg::*;
#(
    parameter int unsigned DIV = DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned      CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // tick flags the wrap happening on this edge; the caller registers it so
    // that dependent counters can advance on the very same edge.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tick  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/temporizador.sv
// Dwell timer: sinal every DIV running cycles, sinal15 every LONG_COUNT sinals.
// Optional macro TEMPORIZADOR_ONESHOT_EN: sinal15 fires once, segundos saturates.
module temporizador
    import temporizador_pkg::*;
#(
    parameter int unsigned DIV        = DIV_DEFAULT,
    parameter int unsigned LONG_COUNT = LONG_COUNT_DEFAULT,
    parameter int unsigned SEC_W      = $clog2(LONG_COUNT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    output logic             sinal,
    output logic             sinal15,
    output logic [SEC_W-1:0] segundos,
    output logic             ativo
);

    localparam logic [SEC_W-1:0] SEG_LAST = SEC_W'(LONG_COUNT - 1);

    estado_t          estado_q, estado_d;
    logic             tick;
    logic             conta;
    logic             sinal_q, sinal_d;
    logic             sinal15_q, sinal15_d;
    logic [SEC_W-1:0] seg_q, seg_d;
`ifdef TEMPORIZADOR_ONESHOT_EN
    logic             disparado_q, disparado_d;
`endif

    // Dropping enable on a tick edge suppresses the tick and freezes the counts.
    assign conta = (estado_q == CONTANDO) && enable;

    divisor_clk #(
        .DIV(DIV)
    ) u_divisor (
        .clk  (clk),
        .reset(reset),
        .en   (conta),
        .clr  (restart),
        .tick (tick)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            PARADO:   if (enable)  estado_d = CONTANDO;
            CONTANDO: if (!enable) estado_d = PARADO;
            default:  estado_d = PARADO;
        endcase
    end

    always_comb begin
        seg_d     = seg_q;
        sinal_d   = tick;
        sinal15_d = 1'b0;
`ifdef TEMPORIZADOR_ONESHOT_EN
        disparado_d = disparado_q;
`endif
        if (restart) begin
            seg_d = '0;
`ifdef TEMPORIZADOR_ONESHOT_EN
            disparado_d = 1'b0;
`endif
        end else if (tick) begin
            if (seg_q == SEG_LAST) begin
`ifdef TEMPORIZADOR_ONESHOT_EN
                if (!disparado_q) begin
                    sinal15_d   = 1'b1;
                    disparado_d = 1'b1;
                end
`else
                seg_d     = '0;
                sinal15_d = 1'b1;
`endif
            end else begin
                seg_d = seg_q + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q  <= PARADO;
            seg_q     <= '0;
            sinal_q   <= 1'b0;
            sinal15_q <= 1'b0;
`ifdef TEMPORIZADOR_ONESHOT_EN
            disparado_q <= 1'b0;
`endif
        end else begin
            estado_q  <= estado_d;
            seg_q     <= seg_d;
            sinal_q   <= sinal_d;
            sinal15_q <= sinal15_d;
`ifdef TEMPORIZADOR_ONESHOT_EN
            disparado_q <= disparado_d;
`endif
        end
    end

    assign sinal    = sinal_q;
    assign sinal15  = sinal15_q;
    assign segundos = seg_q;
    assign ativo    = (estado_q == CONTANDO);

endmodule

// File: doc/temporizador.md
Name: temporizador

Overview:
- Timing source for the state-change pulse detector.
- Divides the system clock into a one-cycle `sinal` tick, and counts those ticks to raise a one-cycle `sinal15` tick after LONG_COUNT of them.
- Both ticks feed the detector's sampling flag.
- The detector's `pulso` output returns here as `restart`, so every controller state change restarts the dwell timing from zero.

Parameters:
- DIV, 50000000: clock cycles per `sinal` tick. Legal range ≥ 2.
- LONG_COUNT, 15: `sinal` ticks per `sinal15` tick. Legal range ≥ 2.
- SEC_W, $clog2(LONG_COUNT): width of `segundos`. Derived; do not override.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run, 0 = pause; counts are held while paused.
- restart  in  1  synchronous clear of all counts; driven by `pulso`.
- sinal  out  1  one-cycle tick, once every DIV enabled cycles.
- sinal15  out  1  one-cycle tick, coincident with every LONG_COUNT-th `sinal`.
- segundos  out  SEC_W  number of `sinal` ticks since the last restart or wrap.
- ativo  out  1  1 while the FSM is in CONTANDO.

Behaviour:
- Reset (reset = 0, asynchronous, at any time including mid-count):
  - prescaler = 0, segundos = 0, sinal = 0, sinal15 = 0, ativo = 0.
  - FSM = PARADO.
- FSM states and transitions:
  - PARADO → CONTANDO when enable = 1.
  - CONTANDO → PARADO when enable = 0.
  - Transitions take effect on the rising edge; `ativo` is the registered state.
- In PARADO:
  - prescaler and segundos hold their values.
  - sinal = 0 and sinal15 = 0.
  - restart still clears the counts.
- Prescaler (counts only in CONTANDO):
  - 0 → DIV-1, then wraps to 0.
  - On the edge where prescaler = DIV-1: sinal <= 1. On all other edges: sinal <= 0.
  - After reset release with enable held at 1, the first `sinal` is high during cycle DIV+1. This includes the one cycle spent in PARADO before CONTANDO.
- Seconds counter:
  - Increments on each edge that sets sinal.
  - On the edge where it would reach LONG_COUNT, it wraps to 0 and sets sinal15 <= 1 on that same edge. `sinal` and `sinal15` are therefore high in the same cycle.
  - `segundos` never shows LONG_COUNT.
- restart = 1 on an edge:
  - prescaler <= 0, segundos <= 0, sinal <= 0, sinal15 <= 0.
  - The FSM state is unchanged.
  - restart has priority over a coincident tick; that tick is lost, not deferred.
- enable dropping on the same edge as a tick: the tick is suppressed and the counts hold.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Arithmetic: counters are unsigned. Prescaler width is $clog2(DIV); no other widths are needed.

Optional Feature:
- Macro: TEMPORIZADOR_ONESHOT_EN.
- Defined:
  - After `sinal15` fires, segundos saturates at LONG_COUNT-1.
  - No further `sinal15` until restart.
  - `sinal` keeps ticking.
- Undefined: segundos wraps and `sinal15` repeats every LONG_COUNT ticks.

Decomposition:
- Package temporizador_pkg holds:
  - the state enum {PARADO, CONTANDO};
  - default constants DIV_DEFAULT and LONG_COUNT_DEFAULT.
- One sub-module: divisor_clk.
  - Parameterised prescaler with inputs clk, reset, en, clr and output tick.
  - temporizador instantiates it and owns the FSM, the seconds counter and sinal15.

Test Plan (bench uses DIV = 4, LONG_COUNT = 15):
- Reset with enable = 1, release at cycle 0 → sinal high in cycles 5, 9, 13, …; segundos = 1 after the first tick; all outputs 0 while reset = 0.
- Run 15 ticks → sinal15 and sinal both high in cycle 61; segundos returns to 0. Without the macro, sinal15 recurs in cycle 121. With TEMPORIZADOR_ONESHOT_EN, sinal15 does not recur and segundos stays at 14.
- Pulse restart for one cycle, coincident with the cycle whose edge would produce a tick → no sinal that cycle; next sinal exactly 4 cycles after the restart edge; segundos = 0.
- Drop enable for 10 cycles at segundos = 7, prescaler = 2 → ativo = 0, no ticks, counts frozen. Re-enable → next sinal 2 cycles after ativo returns to 1.
- Assert reset mid-count at segundos = 12 → all outputs 0 asynchronously, before the next clock edge; after release, timing restarts as in the first scenario.
- Hold restart high continuously → sinal and sinal15 never assert; segundos stays at 0.
